br_cc_sequencer: RTL and testbench
==================================

# br_cc_sequencer

Branch/condition-code sequencer for the LC-3 style datapath. Owns the architectural NZP condition-code register, updated from the bus on `ld_cc`. Accepts BR instructions over a valid/ready handshake, evaluates the branch-enable condition against the registered NZP flags, and issues a single-cycle PC-load command with the computed branch target. Sits between the instruction-register/decode path and the PC mux.

## Interface
Parameters:
- `WIDTH`, default 16: bus, PC and instruction width; must be 16.

Ports:
- `Clk`  input  1  system clock, rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `bus_in`  input  16  datapath bus value for condition-code update.
- `ld_cc`  input  1  load NZP from `bus_in` at the next edge.
- `ir_valid`  input  1  `ir` holds an instruction offered to the block.
- `ir_ready`  output  1  block can accept an instruction.
- `ir`  input  16  instruction; [15:12] opcode, [11:9] n/z/p mask, [8:0] PCoffset9.
- `pc`  input  16  incremented PC, sampled at accept.
- `nzp`  output  3  registered condition codes {N,Z,P}.
- `ben`  output  1  registered branch-enable result of the last evaluation.
- `br_done`  output  1  one-cycle pulse: branch resolved.
- `pc_load`  output  1  one-cycle pulse with `br_done` when branch taken.
- `pc_target`  output  16  branch target, valid while `br_done`=1.
- `ill_op`  output  1  one-cycle pulse with `br_done` when accepted opcode ≠ 4'b0000.

## Operation
- NZP update: on `ld_cc`=1, the next edge loads N=`bus_in[15]`, Z=(`bus_in`==0), P=otherwise. Exactly one flag is set. `ld_cc` is honoured in every state.
- FSM states: IDLE, EVAL, RESOLVE.
- IDLE: `ir_ready`=1. On `ir_valid`&`ir_ready`, latch `ir` and `pc`, then go to EVAL.
- EVAL: if `ld_cc`=1, stay in EVAL (CC hazard stall; see Configuration). Otherwise:
  - `ben` <= (N&ir[11])|(Z&ir[10])|(P&ir[9]).
  - target <= pc + sext(ir[8:0]), modulo 2^16 (wrap-around permitted, no flag).
  - Go to RESOLVE.
- RESOLVE: `br_done`=1. `pc_load`=`ben`. `pc_target`=target. Go to IDLE.
- Opcode ≠ 0000: evaluation is forced to `ben`=0 and `ill_op`=1 in RESOLVE. PC is never loaded.
- Mask 000: never taken. Mask 111: always taken.
- `ir_ready`=0 in EVAL and RESOLVE. `ir_valid` is ignored there; the upstream must hold.
- Reset (asynchronous, at any time, including mid-EVAL/RESOLVE):
  - State IDLE.
  - `nzp`=3'b010 (Z).
  - `ben`=0, `br_done`=0, `pc_load`=0, `ill_op`=0, `pc_target`=0, `ir_ready`=1 after deassert.
  - An in-flight instruction is dropped, with no `br_done`.

## Timing
- Accept at edge k. EVAL during cycle k+1. `br_done` high during cycle k+2 without a stall. Each `ld_cc` cycle in EVAL adds one cycle.
- NZP is visible on `nzp` one cycle after the `ld_cc` edge.
- Back-to-back instructions: next accept no earlier than the edge ending RESOLVE. Maximum throughput is one branch per 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `BR_CC_FWD_EN` defined: `ld_cc` in EVAL does not stall. `ben` is computed from flags derived directly from `bus_in` that cycle, and `nzp` still updates. Latency is fixed at 2 cycles.
- Undefined: stall behaviour as described in Operation.

## Test plan
- Reset, then `ld_cc` with `bus_in`=16'h8000 → `nzp`=3'b100. With 16'h0000 → 3'b010. With 16'h0001 → 3'b001.
- `nzp`=010, BRz (ir=16'h05FE), `pc`=16'h3001 → `br_done` 2 cycles after accept, `pc_load`=1, `pc_target`=16'h2FFF.
- `nzp`=001, BRn (ir=16'h0805) → `br_done`=1, `pc_load`=0, `ben`=0. Mask 000 with any `nzp` → not taken.
- Wrap: `pc`=16'hFFFF, BRnzp offset +1 (ir=16'h0E01) → `pc_target`=16'h0000, `pc_load`=1.
- `ld_cc` (`bus_in`=16'hFFFF) held 2 cycles during EVAL of BRn with prior `nzp`=010:
  - Macro undefined: `br_done` at accept+4, taken.
  - `BR_CC_FWD_EN`: `br_done` at accept+2, taken.
- Reset asserted during EVAL → no `br_done`, `nzp`=010, `ir_ready`=1 after release. ir=16'h1000 → `ill_op`=1, `pc_load`=0.

Source files
------------

// File: rtl/br_cc_sequencer.sv
// br_cc_sequencer
//   Branch/condition-code sequencer for an LC-3 style datapath. Holds the
//   architectural NZP register, accepts BR instructions over a valid/ready
//   handshake, evaluates the branch enable against NZP and issues a
//   single-cycle PC-load command with the branch target.
//
//   Optional build macro: BR_CC_FWD_EN
//     defined   - ld_cc during EVAL does not stall; the flags derived from
//                 bus_in that cycle are forwarded into the evaluation.
//     undefined - ld_cc during EVAL holds the FSM in EVAL (CC hazard stall).
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset
//   bus_in     in   datapath bus, source for NZP update
//   ld_cc      in   load NZP from bus_in at next edge
//   ir_valid   in   instruction offered on ir
//   ir_ready   out  block can accept an instruction (IDLE)
//   ir         in   instruction: [15:12] opcode, [11:9] nzp mask, [8:0] offset
//   pc         in   incremented PC, sampled at accept
//   nzp        out  registered condition codes {N,Z,P}
//   ben        out  registered branch enable of the last evaluation
//   br_done    out  one-cycle pulse, branch resolved
//   pc_load    out  one-cycle pulse with br_done when taken
//   pc_target  out  branch target, valid while br_done
//   ill_op     out  one-cycle pulse with br_done when opcode is not BR
module br_cc_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ld_cc,
   input  logic             ir_valid,
   output logic             ir_ready,
   input  logic [WIDTH-1:0] ir,
   input  logic [WIDTH-1:0] pc,
   output logic [2:0]       nzp,
   output logic             ben,
   output logic             br_done,
   output logic             pc_load,
   output logic [WIDTH-1:0] pc_target,
   output logic             ill_op
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       nzp_q, nzp_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             ben_q, ben_d;
   logic             ill_q, ill_d;

   logic [2:0]       bus_cc;
   logic [2:0]       eval_cc;
   logic             stall;
   logic             is_br;
   logic [WIDTH-1:0] offset_sx;

   // Exactly one flag set: negative, zero, otherwise positive.
   always_comb begin
      if (bus_in[WIDTH-1])
         bus_cc = 3'b100;
      else if (bus_in == '0)
         bus_cc = 3'b010;
      else
         bus_cc = 3'b001;
   end

   assign nzp_d = ld_cc ? bus_cc : nzp_q;

`ifdef BR_CC_FWD_EN
   // Forward the flags being written this cycle instead of stalling.
   assign eval_cc = ld_cc ? bus_cc : nzp_q;
   assign stall   = 1'b0;
`else
   assign eval_cc = nzp_q;
   assign stall   = ld_cc;
`endif

   assign is_br     = (ir_q[15:12] == 4'b0000);
   assign offset_sx = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      ben_d   = ben_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: begin
            if (ir_valid) begin
               ir_d    = ir;
               pc_d    = pc;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (!stall) begin
               ben_d   = is_br & (|(ir_q[11:9] & eval_cc));
               tgt_d   = pc_q + offset_sx;
               ill_d   = ~is_br;
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         nzp_q   <= 3'b010;
         ir_q    <= '0;
         pc_q    <= '0;
         tgt_q   <= '0;
         ben_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nzp_q   <= nzp_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         ben_q   <= ben_d;
         ill_q   <= ill_d;
      end
   end

   assign ir_ready  = (state_q == IDLE);
   assign br_done   = (state_q == RESOLVE);
   assign pc_load   = br_done & ben_q;
   assign ill_op    = br_done & ill_q;
   assign pc_target = tgt_q;
   assign ben       = ben_q;
   assign nzp       = nzp_q;

endmodule

// File: tb/tb_br_cc_sequencer.sv
module tb_br_cc_sequencer;

   logic        Clk;
   logic        Reset;
   logic [15:0] bus_in;
   logic        ld_cc;
   logic        ir_valid;
   logic        ir_ready;
   logic [15:0] ir;
   logic [15:0] pc;
   logic [2:0]  nzp;
   logic        ben;
   logic        br_done;
   logic        pc_load;
   logic [15:0] pc_target;
   logic        ill_op;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference state: architectural condition codes as the spec defines them.
   logic [2:0]  m_nzp;

   br_cc_sequencer #(.WIDTH(16)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .bus_in    (bus_in),
      .ld_cc     (ld_cc),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .ir        (ir),
      .pc        (pc),
      .nzp       (nzp),
      .ben       (ben),
      .br_done   (br_done),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .ill_op    (ill_op)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sign of the bus value as a two's-complement number selects the flag.
   function automatic logic [2:0] flags_of(input logic [15:0] v);
      int signed s;
      s = int'($signed(v));
      if (s < 0)       return 3'b100;
      else if (s == 0) return 3'b010;
      else             return 3'b001;
   endfunction

   task automatic load_cc(input logic [15:0] v);
      ld_cc  = 1'b1;
      bus_in = v;
      step();
      ld_cc  = 1'b0;
      bus_in = 16'($urandom);
      m_nzp  = flags_of(v);
      chk("nzp_load", 32'(nzp), 32'(m_nzp));
   endtask

   // Offer one instruction, optionally hold ld_cc for nstall cycles starting
   // in the cycle after accept, and check the resolution against the model.
   task automatic do_branch(input logic [15:0] i_ir, input logic [15:0] i_pc,
                            input int unsigned nstall, input logic [15:0] sbus);
      int unsigned wcnt;
      int unsigned exp_lat;
      int          off;
      logic [2:0]  ev_flags;
      logic        exp_taken;
      logic        exp_ill;
      logic [15:0] exp_tgt;
      bit          seen;

      wcnt = 0;
      while (ir_ready !== 1'b1 && wcnt < 20) begin
         step();
         wcnt++;
      end
      chk("ready_before_accept", 32'(ir_ready), 32'd1);

      ir_valid = 1'b1;
      ir       = i_ir;
      pc       = i_pc;
      step();
      ir_valid = 1'b0;
      ir       = 16'($urandom);
      pc       = 16'($urandom);
      chk("ready_low_after_accept", 32'(ir_ready), 32'd0);

      ev_flags  = (nstall > 0) ? flags_of(sbus) : m_nzp;
      exp_ill   = (i_ir[15:12] != 4'b0000);
      exp_taken = !exp_ill && ((i_ir[11:9] & ev_flags) != 3'b000);
      off       = i_ir[8] ? int'(i_ir[8:0]) - 512 : int'(i_ir[8:0]);
      exp_tgt   = 16'(int'(i_pc) + off);
`ifdef BR_CC_FWD_EN
      exp_lat   = 2;
`else
      exp_lat   = 2 + nstall;
`endif

      seen = 1'b0;
      for (int unsigned c = 1; c <= 12 && !seen; c++) begin
         ld_cc  = (c <= nstall);
         bus_in = sbus;
         if (br_done === 1'b1) begin
            seen = 1'b1;
            chk("latency",   c,                 exp_lat);
            chk("pc_load",   32'(pc_load),      32'(exp_taken));
            chk("ben",       32'(ben),          32'(exp_taken));
            chk("ill_op",    32'(ill_op),       32'(exp_ill));
            chk("pc_target", 32'(pc_target),    32'(exp_tgt));
            chk("ready_low_resolve", 32'(ir_ready), 32'd0);
         end else begin
            chk("no_pulse_pc_load", 32'(pc_load), 32'd0);
         end
         step();
         if (c <= nstall) m_nzp = flags_of(sbus);
      end
      ld_cc  = 1'b0;
      bus_in = 16'($urandom);
      if (!seen) chk("br_done_timeout", 32'd0, 32'd1);
      chk("nzp_after_branch", 32'(nzp), 32'(m_nzp));
      chk("ready_after_resolve", 32'(ir_ready), 32'd1);
   endtask

   initial begin
      Reset    = 1'b0;
      bus_in   = '0;
      ld_cc    = 1'b0;
      ir_valid = 1'b0;
      ir       = '0;
      pc       = '0;
      m_nzp    = 3'b010;
      #12;
      chk("rst_nzp",       32'(nzp),       32'h2);
      chk("rst_ben",       32'(ben),       32'd0);
      chk("rst_br_done",   32'(br_done),   32'd0);
      chk("rst_pc_load",   32'(pc_load),   32'd0);
      chk("rst_ill_op",    32'(ill_op),    32'd0);
      chk("rst_pc_target", 32'(pc_target), 32'd0);
      Reset = 1'b1;
      step();
      chk("rst_ir_ready",  32'(ir_ready),  32'd1);

      // Condition code loads
      load_cc(16'h8000);
      chk("nzp_neg", 32'(nzp), 32'h4);
      load_cc(16'h0000);
      chk("nzp_zero", 32'(nzp), 32'h2);
      load_cc(16'h0001);
      chk("nzp_pos", 32'(nzp), 32'h1);

      // BRz taken, negative offset
      load_cc(16'h0000);
      do_branch(16'h05FE, 16'h3001, 0, 16'h0000);
      // BRn not taken with P set
      load_cc(16'h0001);
      do_branch(16'h0805, 16'h4000, 0, 16'h0000);
      // Mask 000 never taken
      load_cc(16'h8000);
      do_branch(16'h0005, 16'h1000, 0, 16'h0000);
      // Mask 111 with wrap-around target
      do_branch(16'h0E01, 16'hFFFF, 0, 16'h0000);
      chk("wrap_target_zero", 32'(pc_target), 32'h0);
      // CC hazard: ld_cc of a negative value held 2 cycles during BRn EVAL
      load_cc(16'h0000);
      do_branch(16'h0800, 16'h1234, 2, 16'hFFFF);

      // Reset during EVAL drops the instruction
      load_cc(16'h8000);
      ir_valid = 1'b1;
      ir       = 16'h0E10;
      pc       = 16'h2222;
      step();
      ir_valid = 1'b0;
      #2 Reset = 1'b0;
      #1;
      m_nzp = 3'b010;
      chk("mid_rst_nzp",      32'(nzp),       32'h2);
      chk("mid_rst_br_done",  32'(br_done),   32'd0);
      chk("mid_rst_pc_tgt",   32'(pc_target), 32'd0);
      #2 Reset = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         step();
         chk("post_rst_no_done", 32'(br_done), 32'd0);
      end
      chk("post_rst_ready", 32'(ir_ready), 32'd1);

      // Non-BR opcode
      do_branch(16'h1000, 16'h5555, 0, 16'h0000);
      do_branch(16'hFE01, 16'h0100, 1, 16'h0000);

      // Randomised traffic
      for (int unsigned it = 0; it < 60; it++) begin
         logic [15:0] rir;
         logic [15:0] rbus;
         int unsigned sel;
         rir = 16'($urandom);
         if ($urandom_range(0, 3) != 0) rir[15:12] = 4'b0000;
         sel = $urandom_range(0, 3);
         rbus = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 | 16'($urandom) : 16'($urandom);
         if ($urandom_range(0, 2) == 0) load_cc(rbus);
         for (int unsigned g = $urandom_range(0, 2); g > 0; g--) step();
         rbus = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rbus = 16'h0000;
         do_branch(rir, 16'($urandom), $urandom_range(0, 3), rbus);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
